// File: rtl/amo_exec_unit_if.sv
// Request/response, data-memory and snoop signals of the atomic execution unit.
interface amo_exec_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [4:0]      req_funct5;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    logic            snoop_we;
    logic [XLEN-1:0] snoop_addr;

    // Core, memory and snoop side of the unit
    modport master (
        output req_valid, req_funct5, req_addr, req_wdata,
        output mem_rdata, mem_ack, snoop_we, snoop_addr,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

    // The atomic execution unit itself
    modport slave (
        input  req_valid, req_funct5, req_addr, req_wdata,
        input  mem_rdata, mem_ack, snoop_we, snoop_addr,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/amo_exec_unit.sv
// Atomic memory operation unit: executes LR.W, SC.W and AMO*.W as a
// read-modify-write sequence on the data port and holds the LR/SC reservation.
module amo_exec_unit #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned RSV_GRAN = 2
) (
    input logic            clk,
    input logic            reset,
    amo_exec_unit_if.slave bus
);
    localparam int unsigned GW = XLEN - RSV_GRAN;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    typedef enum logic [3:0] {
        OP_LR, OP_SC, OP_SWAP, OP_ADD, OP_XOR, OP_AND, OP_OR,
        OP_MIN, OP_MAX, OP_MINU, OP_MAXU, OP_BAD
    } op_t;

    state_t          state_q, state_d;
    op_t             req_op, op_q;
    logic [XLEN-1:0] addr_q, rs2_q, rdata_q, wdata_q;
    logic            err_q;
    logic            rsv_valid_q;
    logic [GW-1:0]   rsv_gran_q;

    logic            accept, req_bad, snoop_hit, sc_ok;
    logic [XLEN-1:0] amo_new;

    // Classify the incoming funct5
    always_comb begin
        req_op = OP_BAD;
        case (bus.req_funct5)
            5'b00010: req_op = OP_LR;
            5'b00011: req_op = OP_SC;
            5'b00001: req_op = OP_SWAP;
            5'b00000: req_op = OP_ADD;
            5'b00100: req_op = OP_XOR;
            5'b01100: req_op = OP_AND;
            5'b01000: req_op = OP_OR;
            5'b10000: req_op = OP_MIN;
            5'b10100: req_op = OP_MAX;
            5'b11000: req_op = OP_MINU;
            5'b11100: req_op = OP_MAXU;
            default:  req_op = OP_BAD;
        endcase
    end

    assign accept    = (state_q == IDLE) && bus.req_valid;
    assign req_bad   = (bus.req_addr[1:0] != 2'b00) || (req_op == OP_BAD);
    assign snoop_hit = bus.snoop_we && rsv_valid_q &&
                       (bus.snoop_addr[XLEN-1:RSV_GRAN] == rsv_gran_q);
    // A matching snoop in the accept cycle kills the reservation before the SC sees it
    assign sc_ok     = rsv_valid_q && !snoop_hit &&
                       (bus.req_addr[XLEN-1:RSV_GRAN] == rsv_gran_q);

    // New memory value from the old word and the rs2 operand
    always_comb begin
        amo_new = rs2_q;
        case (op_q)
            OP_ADD:  amo_new = bus.mem_rdata + rs2_q;
            OP_XOR:  amo_new = bus.mem_rdata ^ rs2_q;
            OP_AND:  amo_new = bus.mem_rdata & rs2_q;
            OP_OR:   amo_new = bus.mem_rdata | rs2_q;
            OP_MIN:  amo_new = ($signed(bus.mem_rdata) <= $signed(rs2_q)) ? bus.mem_rdata : rs2_q;
            OP_MAX:  amo_new = ($signed(bus.mem_rdata) >= $signed(rs2_q)) ? bus.mem_rdata : rs2_q;
            OP_MINU: amo_new = (bus.mem_rdata <= rs2_q) ? bus.mem_rdata : rs2_q;
            OP_MAXU: amo_new = (bus.mem_rdata >= rs2_q) ? bus.mem_rdata : rs2_q;
            default: amo_new = rs2_q;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_bad)               state_d = RESP;
                    else if (req_op == OP_SC)  state_d = sc_ok ? WRITE : RESP;
                    else                       state_d = READ;
                end
            end
            READ:    if (bus.mem_ack) state_d = (op_q == OP_LR) ? RESP : WRITE;
            WRITE:   if (bus.mem_ack) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs; data outputs are forced to zero outside their phases
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = (state_q == RESP);
        bus.resp_rdata = (state_q == RESP) ? rdata_q : '0;
        bus.resp_err   = (state_q == RESP) && err_q;
        bus.mem_req    = (state_q == READ) || (state_q == WRITE);
        bus.mem_we     = (state_q == WRITE);
        bus.mem_addr   = ((state_q == READ) || (state_q == WRITE)) ? addr_q : '0;
        bus.mem_wdata  = (state_q == WRITE) ? wdata_q : '0;
    end

    // Operand capture on accept, old value and write data capture on read ack
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= OP_LR;
            addr_q  <= '0;
            rs2_q   <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= bus.req_addr;
                rs2_q   <= bus.req_wdata;
                wdata_q <= bus.req_wdata;
                err_q   <= req_bad;
                if (!req_bad && req_op == OP_SC)
                    rdata_q <= {{(XLEN-1){1'b0}}, !sc_ok};
                else
                    rdata_q <= '0;
            end else if (state_q == READ && bus.mem_ack) begin
                rdata_q <= bus.mem_rdata;
                wdata_q <= amo_new;
            end
        end
    end

    // Reservation: an LR completing its read wins over a same-cycle snoop
    always_ff @(posedge clk) begin
        if (reset) begin
            rsv_valid_q <= 1'b0;
            rsv_gran_q  <= '0;
        end else if (state_q == READ && bus.mem_ack && op_q == OP_LR) begin
            rsv_valid_q <= 1'b1;
            rsv_gran_q  <= addr_q[XLEN-1:RSV_GRAN];
        end else if (snoop_hit) begin
            rsv_valid_q <= 1'b0;
        end else if (accept && !req_bad && req_op == OP_SC) begin
            rsv_valid_q <= 1'b0;
        end else if (state_q == WRITE && bus.mem_ack && op_q != OP_SC &&
                     addr_q[XLEN-1:RSV_GRAN] == rsv_gran_q) begin
            rsv_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_amo_exec_unit.sv
// Directed bench for amo_exec_unit with a word-level memory/reservation model.
module tb_amo_exec_unit;
    localparam logic [4:0] F_LR   = 5'b00010, F_SC   = 5'b00011, F_SWAP = 5'b00001;
    localparam logic [4:0] F_ADD  = 5'b00000, F_XOR  = 5'b00100, F_AND  = 5'b01100;
    localparam logic [4:0] F_OR   = 5'b01000, F_MIN  = 5'b10000, F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000, F_MAXU = 5'b11100, F_BAD  = 5'b11111;

    typedef struct { logic [31:0] rd; logic err; int unsigned lat; } resp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } acc_t;
    typedef struct { logic [31:0] rd; logic err; int unsigned nacc; logic [31:0] wdata; int unsigned lat; } pred_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    amo_exec_unit_if #(.XLEN(32)) bus();

    amo_exec_unit #(.XLEN(32), .RSV_GRAN(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0, checks = 0;
    int unsigned cyc = 0, acc_cyc = 0, resp_seen = 0;
    int unsigned ack_delay = 1;
    logic        allow_mem = 1'b0;

    resp_t exp_resp[$];
    acc_t  exp_acc[$];
    logic [31:0] exp_mem [int unsigned];
    logic [31:0] env_mem [int unsigned];
    logic        rsv_v = 1'b0;
    logic [31:0] rsv_g = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a, input logic env);
        int unsigned k = a >> 2;
        if (env) return env_mem.exists(k) ? env_mem[k] : 32'h0;
        return exp_mem.exists(k) ? exp_mem[k] : 32'h0;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        exp_mem[a >> 2] = d;
        env_mem[a >> 2] = d;
    endtask

    function automatic void model_snoop(input logic [31:0] a);
        if (rsv_v && (a >> 2) == rsv_g) rsv_v = 1'b0;
    endfunction

    // Architectural effect of one request; queues the memory accesses it must make
    function automatic pred_t model_req(input logic [4:0] f, input logic [31:0] a, input logic [31:0] rs2);
        pred_t p;
        logic [31:0] old, nv;
        logic supported;
        supported = f inside {F_LR, F_SC, F_SWAP, F_ADD, F_XOR, F_AND, F_OR,
                              F_MIN, F_MAX, F_MINU, F_MAXU};
        p.rd = 32'h0; p.err = 1'b0; p.nacc = 0; p.wdata = 32'h0;
        if (a[1:0] != 2'b00 || !supported) begin
            p.err = 1'b1;
        end else if (f == F_LR) begin
            p.rd = rd_word(a, 1'b0);
            p.nacc = 1;
            exp_acc.push_back('{1'b0, a, 32'h0});
            rsv_v = 1'b1;
            rsv_g = a >> 2;
        end else if (f == F_SC) begin
            if (rsv_v && (a >> 2) == rsv_g) begin
                p.rd = 32'h0;
                p.nacc = 1;
                p.wdata = rs2;
                exp_acc.push_back('{1'b1, a, rs2});
                exp_mem[a >> 2] = rs2;
            end else begin
                p.rd = 32'h1;
            end
            rsv_v = 1'b0;
        end else begin
            old = rd_word(a, 1'b0);
            case (f)
                F_ADD:   nv = old + rs2;
                F_XOR:   nv = old ^ rs2;
                F_AND:   nv = old & rs2;
                F_OR:    nv = old | rs2;
                F_MIN:   nv = ($signed(rs2) < $signed(old)) ? rs2 : old;
                F_MAX:   nv = ($signed(rs2) > $signed(old)) ? rs2 : old;
                F_MINU:  nv = (rs2 < old) ? rs2 : old;
                F_MAXU:  nv = (rs2 > old) ? rs2 : old;
                default: nv = rs2;
            endcase
            p.rd = old;
            p.nacc = 2;
            p.wdata = nv;
            exp_acc.push_back('{1'b0, a, 32'h0});
            exp_acc.push_back('{1'b1, a, nv});
            exp_mem[a >> 2] = nv;
            if (rsv_v && (a >> 2) == rsv_g) rsv_v = 1'b0;
        end
        p.lat = 1 + p.nacc * (ack_delay + 1);
        return p;
    endfunction

    // Memory responder: acks after ack_delay waiting cycles
    initial begin
        int unsigned wait_cnt = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (bus.mem_req && !reset) begin
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) begin
                        env_mem[bus.mem_addr >> 2] = bus.mem_wdata;
                        bus.mem_rdata = 32'hBAD0BAD0;
                    end else begin
                        bus.mem_rdata = rd_word(bus.mem_addr, 1'b1);
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Compare process: DUT outputs against the model every cycle out of reset
    initial begin
        forever begin
            @(negedge clk);
            if (reset) continue;
            if (!allow_mem) chk("no_mem_access", bus.mem_req, 1'b0);
            if (bus.mem_req) begin
                chk("ready_while_busy", bus.req_ready, 1'b0);
                if (exp_acc.size() > 0) begin
                    chk("mem_addr", bus.mem_addr, exp_acc[0].addr);
                    chk("mem_we", bus.mem_we, exp_acc[0].we);
                end
                if (bus.mem_ack) begin
                    if (exp_acc.size() == 0) begin
                        fail("unexpected_mem_access");
                    end else begin
                        if (exp_acc[0].we) chk("mem_wdata", bus.mem_wdata, exp_acc[0].data);
                        void'(exp_acc.pop_front());
                    end
                end
            end
            if (bus.resp_valid) begin
                if (exp_resp.size() == 0) begin
                    fail("unexpected_resp");
                end else begin
                    chk("resp_rdata", bus.resp_rdata, exp_resp[0].rd);
                    chk("resp_err", bus.resp_err, exp_resp[0].err);
                    chk("resp_latency", cyc - acc_cyc + 1, exp_resp[0].lat);
                    void'(exp_resp.pop_front());
                end
                resp_seen++;
            end
        end
    end

    task automatic do_req(input logic [4:0] f, input logic [31:0] a, input logic [31:0] rs2,
                          input logic snoop, output pred_t p);
        int unsigned n = 0;
        int unsigned start;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) fail("ready_timeout");
        if (snoop) model_snoop(a);
        p = model_req(f, a, rs2);
        exp_resp.push_back('{p.rd, p.err, p.lat});
        allow_mem = (p.nacc > 0);
        start = resp_seen;
        bus.req_valid = 1'b1;
        bus.req_funct5 = f;
        bus.req_addr = a;
        bus.req_wdata = rs2;
        bus.snoop_we = snoop;
        bus.snoop_addr = a;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.req_valid = 1'b0;
        bus.req_funct5 = 5'b10101;
        bus.req_addr = 32'hFFFF_FFFF;
        bus.req_wdata = 32'hA5A5_A5A5;
        bus.snoop_we = 1'b0;
        n = 0;
        while (resp_seen == start && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (resp_seen == start) begin
            fail("resp_timeout");
            exp_resp.delete();
            exp_acc.delete();
        end
        allow_mem = 1'b0;
    endtask

    task automatic do_snoop(input logic [31:0] a);
        @(negedge clk);
        bus.snoop_we = 1'b1;
        bus.snoop_addr = a;
        model_snoop(a);
        @(posedge clk);
        #1;
        bus.snoop_we = 1'b0;
    endtask

    task automatic chk_reset_state();
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_resp_err", bus.resp_err, 1'b0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        pred_t p;
        int unsigned n;
        bus.req_valid = 1'b0;
        bus.req_funct5 = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.snoop_we = 1'b0;
        bus.snoop_addr = '0;
        preload(32'h100, 32'hDEADBEEF);
        preload(32'h200, 32'hFFFFFFFF);
        preload(32'h204, 32'h80000000);
        preload(32'h208, 32'h80000000);
        preload(32'h300, 32'h12345678);
        preload(32'h400, 32'h00000011);
        preload(32'h500, 32'h00000055);
        preload(32'h600, 32'h00000066);

        repeat (3) @(posedge clk);
        #1;
        chk_reset_state();
        @(negedge clk);
        reset = 1'b0;

        // LR then successful SC
        do_req(F_LR, 32'h100, 32'h0, 1'b0, p);
        chk("pin_lr_rd", p.rd, 32'hDEADBEEF);
        chk("pin_lr_lat", p.lat, 3);
        do_req(F_SC, 32'h100, 32'h5, 1'b0, p);
        chk("pin_sc_rd", p.rd, 32'h0);
        chk("pin_sc_wdata", p.wdata, 32'h5);
        chk("pin_sc_lat", p.lat, 3);

        // Snoop breaks the reservation; both SCs fail
        do_req(F_LR, 32'h100, 32'h0, 1'b0, p);
        do_snoop(32'h100);
        do_req(F_SC, 32'h100, 32'h7, 1'b0, p);
        chk("pin_scfail_rd", p.rd, 32'h1);
        chk("pin_scfail_lat", p.lat, 1);
        do_req(F_SC, 32'h100, 32'h7, 1'b0, p);

        // Read-modify-write operations
        do_req(F_ADD, 32'h200, 32'h2, 1'b0, p);
        chk("pin_add_rd", p.rd, 32'hFFFFFFFF);
        chk("pin_add_wdata", p.wdata, 32'h00000001);
        chk("pin_add_lat", p.lat, 5);
        do_req(F_MIN, 32'h204, 32'h1, 1'b0, p);
        chk("pin_min_wdata", p.wdata, 32'h80000000);
        do_req(F_MINU, 32'h208, 32'h1, 1'b0, p);
        chk("pin_minu_wdata", p.wdata, 32'h00000001);
        do_req(F_SWAP, 32'h200, 32'hAA, 1'b0, p);
        do_req(F_XOR, 32'h200, 32'hFF, 1'b0, p);
        chk("pin_xor_wdata", p.wdata, 32'h55);
        do_req(F_AND, 32'h200, 32'h0F, 1'b0, p);
        do_req(F_OR, 32'h200, 32'hF0, 1'b0, p);
        chk("pin_or_wdata", p.wdata, 32'hF5);
        do_req(F_MAX, 32'h204, 32'h1, 1'b0, p);
        do_req(F_MIN, 32'h204, 32'h1, 1'b0, p);
        do_req(F_MAXU, 32'h208, 32'hFFFF0000, 1'b0, p);
        chk("pin_maxu_wdata", p.wdata, 32'hFFFF0000);

        // Errors leave the reservation alone
        do_req(F_LR, 32'h100, 32'h0, 1'b0, p);
        do_req(F_SWAP, 32'h102, 32'h1, 1'b0, p);
        chk("pin_misalign_err", p.err, 1'b1);
        do_req(F_BAD, 32'h100, 32'h1, 1'b0, p);
        chk("pin_badop_err", p.err, 1'b1);
        do_req(F_SC, 32'h100, 32'h9, 1'b0, p);
        chk("pin_sc_after_err_rd", p.rd, 32'h0);

        // Own AMO write and a newer LR both drop the reservation
        do_req(F_LR, 32'h100, 32'h0, 1'b0, p);
        do_req(F_ADD, 32'h100, 32'h0, 1'b0, p);
        do_req(F_SC, 32'h100, 32'h3, 1'b0, p);
        do_req(F_LR, 32'h100, 32'h0, 1'b0, p);
        do_req(F_LR, 32'h200, 32'h0, 1'b0, p);
        do_req(F_SC, 32'h100, 32'h3, 1'b0, p);

        // Slow memory
        ack_delay = 4;
        do_req(F_LR, 32'h600, 32'h0, 1'b0, p);
        chk("pin_slow_lr_lat", p.lat, 6);
        ack_delay = 1;

        // Reset during the write phase of an AMO
        do_req(F_LR, 32'h400, 32'h0, 1'b0, p);
        @(negedge clk);
        exp_acc.push_back('{1'b0, 32'h500, 32'h0});
        allow_mem = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_funct5 = F_ADD;
        bus.req_addr = 32'h500;
        bus.req_wdata = 32'h1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!(bus.mem_req && bus.mem_we) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reached_write", bus.mem_req && bus.mem_we, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_mem_req", bus.mem_req, 1'b0);
        chk("abort_resp_valid", bus.resp_valid, 1'b0);
        chk_reset_state();
        @(negedge clk);
        reset = 1'b0;
        allow_mem = 1'b0;
        exp_acc.delete();
        exp_resp.delete();
        rsv_v = 1'b0;
        do_req(F_SC, 32'h400, 32'h7, 1'b0, p);
        chk("pin_sc_after_reset_rd", p.rd, 32'h1);
        do_req(F_LR, 32'h500, 32'h0, 1'b0, p);
        chk("pin_aborted_mem_rd", p.rd, 32'h55);

        // Snoop in the SC accept cycle
        do_req(F_LR, 32'h300, 32'h0, 1'b0, p);
        do_req(F_SC, 32'h300, 32'h9, 1'b1, p);
        chk("pin_sc_snoop_rd", p.rd, 32'h1);
        do_req(F_LR, 32'h300, 32'h0, 1'b0, p);
        chk("pin_sc_snoop_nowrite", p.rd, 32'h12345678);

        repeat (5) @(negedge clk);
        if (exp_resp.size() != 0 || exp_acc.size() != 0) fail("leftover_expectations");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
